// File: rtl/change_if.sv
// Change-request handshake between the vending controller and the change dispenser.
interface change_if #(
  parameter int unsigned CNT_W = 5
) ();
  logic             change_valid;
  logic [CNT_W-1:0] change_coins;
  logic             ready;

  // Upstream side: presents a request and holds it until accepted
  modport master (output change_valid, output change_coins, input ready);
  // Dispenser side: accepts the request when ready is high
  modport slave  (input change_valid, input change_coins, output ready);
endinterface

// File: rtl/change_dispenser.sv
// Coin-hopper driver: pays out a requested coin count one coin at a time,
// confirming each coin on the exit sensor and latching a fault on a jam or empty hopper.
module change_dispenser #(
  parameter int unsigned CNT_W          = 5,
  parameter int unsigned PULSE_CYCLES   = 4,
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned GAP_CYCLES     = 2
) (
  input  logic             clk,
  input  logic             rst,
  change_if.slave          req,
  input  logic             coin_sense,
  input  logic             fault_clr,
  output logic             motor_en,
  output logic [CNT_W-1:0] coins_left,
  output logic             done,
  output logic             fault
);

  localparam int unsigned MAX_A = (PULSE_CYCLES > TIMEOUT_CYCLES) ? PULSE_CYCLES : TIMEOUT_CYCLES;
  localparam int unsigned MAX_C = (MAX_A > GAP_CYCLES) ? MAX_A : GAP_CYCLES;
  localparam int unsigned CW    = (MAX_C > 1) ? $clog2(MAX_C) : 1;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    PULSE      = 3'd1,
    WAIT_SENSE = 3'd2,
    GAP        = 3'd3,
    FAULT      = 3'd4
  } state_t;

  state_t           state, state_nx;
  logic [CW-1:0]    cnt, cnt_nx;
  logic             sensed, sensed_nx;
  logic [CNT_W-1:0] coins_nx;
  logic             done_nx;
  logic             ready_q;

  assign req.ready = ready_q;

  // Next-state, counter and coin bookkeeping
  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    sensed_nx = sensed;
    coins_nx  = coins_left;
    done_nx   = 1'b0;
    case (state)
      IDLE: begin
        if (req.change_valid && ready_q) begin
          if (req.change_coins == '0) begin
            done_nx = 1'b1;
          end else begin
            coins_nx  = CNT_W'(req.change_coins);
            state_nx  = PULSE;
            cnt_nx    = '0;
            sensed_nx = 1'b0;
          end
        end
      end
      PULSE: begin
        // A coin seen mid-pulse is counted now; the pulse still runs to full length
        if (coin_sense && !sensed && (coins_left != '0)) begin
          coins_nx  = coins_left - CNT_W'(1);
          sensed_nx = 1'b1;
        end
        if (cnt == CW'(PULSE_CYCLES - 1)) begin
          cnt_nx = '0;
          if (sensed_nx) begin
            if (coins_nx == '0) begin
              state_nx = IDLE;
              done_nx  = 1'b1;
            end else begin
              state_nx = GAP;
            end
          end else begin
            state_nx = WAIT_SENSE;
          end
        end else begin
          cnt_nx = cnt + CW'(1);
        end
      end
      WAIT_SENSE: begin
        if (coin_sense && (coins_left != '0)) begin
          coins_nx  = coins_left - CNT_W'(1);
          sensed_nx = 1'b1;
          cnt_nx    = '0;
          if (coins_nx == '0) begin
            state_nx = IDLE;
            done_nx  = 1'b1;
          end else begin
            state_nx = GAP;
          end
        end else if (cnt == CW'(TIMEOUT_CYCLES - 1)) begin
          state_nx = FAULT;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + CW'(1);
        end
      end
      GAP: begin
        if (cnt == CW'(GAP_CYCLES - 1)) begin
          state_nx  = PULSE;
          cnt_nx    = '0;
          sensed_nx = 1'b0;
        end else begin
          cnt_nx = cnt + CW'(1);
        end
      end
      FAULT: begin
        // Unpaid count is held for inspection until the fault is cleared
        if (fault_clr) begin
          state_nx = IDLE;
          coins_nx = '0;
        end
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
        coins_nx = '0;
      end
    endcase
  end

  // State, counters and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= '0;
      sensed     <= 1'b0;
      coins_left <= '0;
      done       <= 1'b0;
      ready_q    <= 1'b1;
      motor_en   <= 1'b0;
      fault      <= 1'b0;
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      sensed     <= sensed_nx;
      coins_left <= coins_nx;
      done       <= done_nx;
      ready_q    <= (state_nx == IDLE);
      motor_en   <= (state_nx == PULSE);
      fault      <= (state_nx == FAULT);
    end
  end

endmodule

// File: tb/tb_change_dispenser.sv
// Directed bench for change_dispenser with a coins_left scoreboard and pulse-length monitor.
module tb_change_dispenser;
  localparam int unsigned CNT_W   = 5;
  localparam int unsigned PULSE_C = 4;
  localparam int unsigned TMO_C   = 16;
  localparam int unsigned GAP_C   = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  bit   run_clk = 1'b0;
  logic coin_sense = 1'b0;
  logic fault_clr = 1'b0;
  logic motor_en, done, fault;
  logic [CNT_W-1:0] coins_left;

  change_if #(.CNT_W(CNT_W)) cif ();

  change_dispenser #(
    .CNT_W(CNT_W), .PULSE_CYCLES(PULSE_C), .TIMEOUT_CYCLES(TMO_C), .GAP_CYCLES(GAP_C)
  ) dut (
    .clk(clk), .rst(rst), .req(cif), .coin_sense(coin_sense), .fault_clr(fault_clr),
    .motor_en(motor_en), .coins_left(coins_left), .done(done), .fault(fault)
  );

  always begin
    #5;
    if (run_clk) clk = ~clk;
  end

  int checks = 0;
  int failures = 0;
  int coin_q[$];
  int done_exp = 0;
  int done_seen = 0;
  int pulse_cnt = 0;
  int run_len = 0;
  logic [CNT_W-1:0] prev_coins = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Scoreboard: every coins_left change must match the next expected value
  always @(negedge clk) begin
    if (rst) begin
      if (coins_left !== prev_coins) begin
        if (coin_q.size() == 0) check("coin_unexpected", 32'(coins_left), 32'(prev_coins));
        else check("coins_left", 32'(coins_left), 32'(coin_q.pop_front()));
      end
      if (done === 1'b1) done_seen++;
      if (done === 1'b1 || fault === 1'b1) check("done_fault_excl", 32'(done & fault), 32'd0);
      if (motor_en === 1'b1) run_len++;
      else if (run_len != 0) begin
        check("pulse_len", 32'(run_len), 32'(PULSE_C));
        pulse_cnt++;
        run_len = 0;
      end
    end else begin
      run_len = 0;
    end
    prev_coins = coins_left;
  end

  task automatic send(input logic [CNT_W-1:0] n);
    int k = 0;
    while (cif.ready !== 1'b1 && k < 100) begin @(negedge clk); k++; end
    check("ready_wait", 32'(k < 100), 32'd1);
    cif.change_valid = 1'b1;
    cif.change_coins = n;
    @(posedge clk); #1;
    cif.change_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_motor_off();
    int k = 0;
    while (motor_en !== 1'b1 && k < 100) begin @(negedge clk); k++; end
    while (motor_en === 1'b1 && k < 100) begin @(negedge clk); k++; end
    check("motor_wait", 32'(k < 100), 32'd1);
  endtask

  task automatic pulse_sense();
    coin_sense = 1'b1;
    @(negedge clk);
    coin_sense = 1'b0;
  endtask

  task automatic gap_len(input int exp);
    int n = 0;
    while (motor_en !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    check("gap_len", 32'(n), 32'(exp));
  endtask

  initial begin
    int n;
    int p0;
    cif.change_valid = 1'b0;
    cif.change_coins = '0;

    // Reset with no clock running
    #1 rst = 1'b0;
    #20;
    check("rst_ready", 32'(cif.ready), 32'd1);
    check("rst_motor", 32'(motor_en), 32'd0);
    check("rst_coins", 32'(coins_left), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_fault", 32'(fault), 32'd0);
    run_clk = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);

    // Normal payout of 3, sense two cycles after each pulse
    coin_q.push_back(3);
    send(5'd3);
    for (int i = 0; i < 3; i++) begin
      wait_motor_off();
      @(negedge clk);
      coin_q.push_back(2 - i);
      if (i == 2) done_exp++;
      pulse_sense();
      if (i < 2) gap_len(GAP_C);
      else begin
        check("t2_done", 32'(done), 32'd1);
        check("t2_ready", 32'(cif.ready), 32'd1);
      end
    end
    repeat (3) @(negedge clk);
    check("t2_done_count", 32'(done_seen), 32'(done_exp));
    check("t2_pulses", 32'(pulse_cnt), 32'd3);

    // Zero change, plus stray sense and fault_clr while idle
    p0 = pulse_cnt;
    done_exp++;
    send(5'd0);
    check("t3_done", 32'(done), 32'd1);
    check("t3_ready", 32'(cif.ready), 32'd1);
    pulse_sense();
    fault_clr = 1'b1;
    @(negedge clk);
    fault_clr = 1'b0;
    repeat (4) @(negedge clk);
    check("t3_done_count", 32'(done_seen), 32'(done_exp));
    check("t3_no_motor", 32'(pulse_cnt), 32'(p0));
    check("t3_ready_hold", 32'(cif.ready), 32'd1);

    // Jam: second coin never sensed
    coin_q.push_back(2);
    send(5'd2);
    wait_motor_off();
    coin_q.push_back(1);
    pulse_sense();
    gap_len(GAP_C);
    wait_motor_off();
    n = 1;
    while (fault !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    check("t4_fault_time", 32'(n), 32'(TMO_C + 1));
    check("t4_coins", 32'(coins_left), 32'd1);
    check("t4_ready", 32'(cif.ready), 32'd0);
    check("t4_motor", 32'(motor_en), 32'd0);
    pulse_sense();
    check("t4_fault_hold", 32'(fault), 32'd1);
    coin_q.push_back(0);
    fault_clr = 1'b1;
    @(negedge clk);
    fault_clr = 1'b0;
    check("t4_clr_ready", 32'(cif.ready), 32'd1);
    check("t4_clr_coins", 32'(coins_left), 32'd0);
    check("t4_clr_fault", 32'(fault), 32'd0);

    // Busy hold-off: 1-coin payout while a 5-coin request is held
    coin_q.push_back(1);
    cif.change_valid = 1'b1;
    cif.change_coins = 5'd1;
    @(posedge clk); #1;
    cif.change_coins = 5'd5;
    @(negedge clk);
    check("t5_busy", 32'(cif.ready), 32'd0);
    wait_motor_off();
    coin_q.push_back(0);
    done_exp++;
    pulse_sense();
    check("t5_done", 32'(done), 32'd1);
    coin_q.push_back(5);
    @(posedge clk); #1;
    cif.change_valid = 1'b0;
    @(negedge clk);
    check("t5_accept_ready", 32'(cif.ready), 32'd0);
    check("t5_accept_coins", 32'(coins_left), 32'd5);
    check("t5_accept_motor", 32'(motor_en), 32'd1);
    // Five coins; the fourth is sensed mid-pulse, then a stray sense in GAP
    for (int i = 0; i < 5; i++) begin
      coin_q.push_back(4 - i);
      if (i == 4) done_exp++;
      if (i == 3) begin
        pulse_sense();
        wait_motor_off();
        check("t6_skip_wait", 32'(coins_left), 32'd1);
        pulse_sense();
        gap_len(1);
      end else begin
        wait_motor_off();
        pulse_sense();
        if (i < 4) gap_len(GAP_C);
        else check("t5_done_last", 32'(done), 32'd1);
      end
    end
    repeat (3) @(negedge clk);
    check("t5_done_count", 32'(done_seen), 32'(done_exp));

    // Reset mid-pulse drops the motor immediately and discards the request
    coin_q.push_back(3);
    send(5'd3);
    @(negedge clk);
    check("t6_motor_on", 32'(motor_en), 32'd1);
    #2 rst = 1'b0;
    #1;
    check("t6_rst_motor", 32'(motor_en), 32'd0);
    check("t6_rst_coins", 32'(coins_left), 32'd0);
    check("t6_rst_ready", 32'(cif.ready), 32'd1);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    p0 = pulse_cnt;
    repeat (10) @(negedge clk);
    check("t6_discarded", 32'(motor_en), 32'd0);
    check("t6_no_pulse", 32'(pulse_cnt), 32'(p0));
    check("scoreboard_empty", 32'(coin_q.size()), 32'd0);
    check("done_total", 32'(done_seen), 32'(done_exp));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
